// File: rtl/curve_lut_loader.sv
// Runtime-programmable 8-bit tone-curve LUT: double-banked curve storage with host
// loading into the shadow bank, frame-aligned bank swap and a 2-cycle registered lookup.
module curve_lut_loader #(
  parameter bit VSYNC_POL = 1'b1,
  parameter bit BYPASS    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       cfg_commit,
  output logic       commit_pending,
  output logic       active_bank,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_Y,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_Y
);

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ARMED = 2'd2
  } state_t;

  typedef struct packed {
    logic vsync;
    logic href;
    logic clken;
  } sync_t;

  state_t        state, state_d;
  logic [AW-1:0] init_cnt, init_cnt_d;
  logic          bank_sel_d;
  logic          init_we;
  logic          host_we;
  logic          vsync_edge;

  logic [DW-1:0] bank0 [DEPTH];
  logic [DW-1:0] bank1 [DEPTH];

  sync_t         s1_sync, s2_sync;
  logic [AW-1:0] s1_addr;
  logic          s1_bypass;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] s2_data_d;

  // S1 holds last cycle's vsync, so it doubles as the edge-detect history register
  assign vsync_edge = (per_frame_vsync == VSYNC_POL) && (s1_sync.vsync != VSYNC_POL);

  // Next-state logic: identity init, host loading, armed swap on frame boundary
  always_comb begin
    state_d    = state;
    init_cnt_d = init_cnt;
    bank_sel_d = active_bank;
    init_we    = 1'b0;
    host_we    = 1'b0;
    case (state)
      ST_INIT: begin
        init_we    = 1'b1;
        init_cnt_d = init_cnt + AW'(1);
        if (init_cnt == AW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        host_we = cfg_valid;
        if (cfg_commit) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (vsync_edge) begin
          bank_sel_d = ~active_bank;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Control state; handshake and status outputs are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_INIT;
      init_cnt       <= '0;
      active_bank    <= 1'b0;
      cfg_ready      <= 1'b0;
      commit_pending <= 1'b0;
    end else begin
      state          <= state_d;
      init_cnt       <= init_cnt_d;
      active_bank    <= bank_sel_d;
      cfg_ready      <= (state_d == ST_IDLE);
      commit_pending <= (state_d == ST_ARMED);
    end
  end

  // Curve storage: init fills both banks, host writes only ever touch the shadow bank
  always_ff @(posedge clk) begin
    if (init_we) begin
      bank0[init_cnt] <= DW'(init_cnt);
      bank1[init_cnt] <= DW'(init_cnt);
    end
    if (host_we && active_bank) begin
      bank0[cfg_addr] <= cfg_data;
    end
    if (host_we && !active_bank) begin
      bank1[cfg_addr] <= cfg_data;
    end
  end

  assign rd_data   = active_bank ? bank1[s1_addr] : bank0[s1_addr];
  assign s2_data_d = s1_bypass ? DW'(s1_addr) : rd_data;

  // Two-stage lookup pipeline; advances every clock regardless of clken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sync    <= '0;
      s1_addr    <= '0;
      s1_bypass  <= 1'b0;
      s2_sync    <= '0;
      post_img_Y <= '0;
    end else begin
      s1_sync    <= '{vsync: per_frame_vsync, href: per_frame_href, clken: per_frame_clken};
      s1_addr    <= per_img_Y;
      s1_bypass  <= BYPASS || (state_d == ST_INIT);
      s2_sync    <= s1_sync;
      post_img_Y <= (s1_sync.href && s1_sync.clken) ? s2_data_d : '0;
    end
  end

  assign post_frame_vsync = s2_sync.vsync;
  assign post_frame_href  = s2_sync.href;
  assign post_frame_clken = s2_sync.clken;

endmodule

// File: tb/tb_curve_lut_loader.sv
// Directed bench for curve_lut_loader: a reference curve/FSM model feeds a scoreboard queue
// of expected pixel outputs, compared two cycles later against a normal and a bypass instance.
module tb_curve_lut_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid, cfg_commit;
  logic [7:0] cfg_addr, cfg_data;
  logic       vsync, href, clken;
  logic [7:0] y_in;

  logic       cfg_ready, commit_pending, active_bank;
  logic       post_vsync, post_href, post_clken;
  logic [7:0] post_y;

  logic       cfg_ready_b, commit_pending_b, active_bank_b;
  logic       post_vsync_b, post_href_b, post_clken_b;
  logic [7:0] post_y_b;

  always #5 clk = ~clk;

  curve_lut_loader #(.VSYNC_POL(1'b1), .BYPASS(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .commit_pending(commit_pending), .active_bank(active_bank),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken), .per_img_Y(y_in),
    .post_frame_vsync(post_vsync), .post_frame_href(post_href), .post_frame_clken(post_clken),
    .post_img_Y(post_y)
  );

  curve_lut_loader #(.VSYNC_POL(1'b1), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_b), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .commit_pending(commit_pending_b), .active_bank(active_bank_b),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken), .per_img_Y(y_in),
    .post_frame_vsync(post_vsync_b), .post_frame_href(post_href_b), .post_frame_clken(post_clken_b),
    .post_img_Y(post_y_b)
  );

  typedef struct {
    logic [7:0] y;
    logic [7:0] yb;
    logic       vs;
    logic       hs;
    logic       ck;
  } exp_t;

  exp_t       q[$];
  int         n_assert = 0;
  int         n_fail   = 0;

  logic [7:0] m_bank [2][256];
  logic       m_act, m_armed, m_vs_prev;
  int         m_init_left;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 256; i++) m_bank[b][i] = 8'(i);
    m_act       = 1'b0;
    m_armed     = 1'b0;
    m_vs_prev   = 1'b0;
    m_init_left = 256;
    q.delete();
  endtask

  // One clock: advance the model with the inputs about to be sampled, then check after the edge
  task automatic step();
    exp_t e;
    if (m_init_left > 0) begin
      m_init_left--;
    end else if (!m_armed) begin
      if (cfg_valid) m_bank[~m_act][cfg_addr] = cfg_data;
      if (cfg_commit) m_armed = 1'b1;
    end else if (vsync && !m_vs_prev) begin
      m_act   = ~m_act;
      m_armed = 1'b0;
    end
    m_vs_prev = vsync;
    e.y  = (href && clken) ? m_bank[m_act][y_in] : 8'h00;
    e.yb = (href && clken) ? y_in : 8'h00;
    e.vs = vsync;
    e.hs = href;
    e.ck = clken;
    q.push_back(e);
    @(posedge clk);
    #1;
    chk("cfg_ready", 8'(cfg_ready), 8'(m_init_left == 0 && !m_armed));
    chk("commit_pending", 8'(commit_pending), 8'(m_armed));
    chk("active_bank", 8'(active_bank), 8'(m_act));
    if (q.size() == 2) begin
      e = q.pop_front();
      chk("post_img_Y", post_y, e.y);
      chk("post_img_Y_bypass", post_y_b, e.yb);
      chk("post_vsync", 8'(post_vsync), 8'(e.vs));
      chk("post_href", 8'(post_href), 8'(e.hs));
      chk("post_clken", 8'(post_clken), 8'(e.ck));
    end
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic pix(input logic [7:0] v, input int n);
    y_in = v; href = 1'b1; clken = 1'b1;
    repeat (n) step();
  endtask

  task automatic blank(input int n);
    href = 1'b0; clken = 1'b0;
    repeat (n) step();
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    step();
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    step();
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1; step();
    vsync = 1'b0; step();
  endtask

  task automatic load_inverse();
    href = 1'b0; clken = 1'b0;
    for (int i = 0; i < 256; i++) host_write(8'(i), 8'(255 - i));
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_post_img_Y", post_y, 8'h00);
    chk("rst_post_href", 8'(post_href), 8'h00);
    chk("rst_post_clken", 8'(post_clken), 8'h00);
    chk("rst_post_vsync", 8'(post_vsync), 8'h00);
    chk("rst_commit_pending", 8'(commit_pending), 8'h00);
    chk("rst_active_bank", 8'(active_bank), 8'h00);
    chk("rst_cfg_ready", 8'(cfg_ready), 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b1; cfg_valid = 1'b0; cfg_commit = 1'b0; cfg_addr = '0; cfg_data = '0;
    vsync = 1'b0; href = 1'b0; clken = 1'b0; y_in = '0;

    // 1: reset, identity init, 2-cycle latency
    do_reset();
    blank(256);
    pix(8'h37, 4);
    pix(8'hC4, 2);

    // 2: inverse curve into shadow, swap only at the vsync rising edge
    load_inverse();
    commit();
    pix(8'h10, 4);
    vsync = 1'b1;
    pix(8'h10, 3);
    vsync = 1'b0;
    pix(8'h10, 2);
    pix(8'hFF, 2);

    // 3: write and commit in the same cycle
    blank(1);
    cfg_valid = 1'b1; cfg_commit = 1'b1; cfg_addr = 8'h80; cfg_data = 8'h00;
    step();
    pix(8'h80, 3);
    vsync_pulse();
    pix(8'h80, 2);
    pix(8'h10, 2);

    // 4: repeated commit and ignored write while armed, two vsyncs give one toggle
    commit();
    pix(8'h20, 2);
    cfg_commit = 1'b1; cfg_valid = 1'b1; cfg_addr = 8'h20; cfg_data = 8'h55;
    step();
    vsync_pulse();
    blank(3);
    href = 1'b1; clken = 1'b0; y_in = 8'h20; step();
    vsync_pulse();
    pix(8'h20, 3);
    pix(8'h80, 2);

    // 5: reset mid-line while armed
    load_inverse();
    commit();
    pix(8'h44, 3);
    do_reset();
    pix(8'h44, 256);
    pix(8'h80, 2);
    pix(8'h10, 2);

    // 6: bypass instance ignores a loaded inverse curve
    load_inverse();
    commit();
    vsync_pulse();
    pix(8'h00, 2);
    pix(8'h5A, 2);
    pix(8'hFF, 2);
    blank(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
